pipeline_hazard_scheduler: RTL and testbench
============================================

Name: pipeline_hazard_scheduler

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Merges three events into one consistent set of pipeline-register controls:
  - load-use hazards detected in ID;
  - taken-branch flushes resolved in ID;
  - multi-cycle data-memory accesses in MEM, run through a req/ack handshake.
- Sits beside the pipeline registers and drives PC write enable, IF/ID write/flush, ID/EX bubble insertion and a global freeze.

Parameters:
- TIMEOUT, 64, maximum cycles to wait for mem_ack_i before declaring a memory error.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- ID_RS1addr_i  input  5  rs1 of the instruction in ID.
- ID_RS2addr_i  input  5  rs2 of the instruction in ID.
- EX_RDaddr_i  input  5  rd of the instruction in EX.
- EX_MemRead_i  input  1  instruction in EX is a load.
- ID_BranchTaken_i  input  1  branch in ID resolved taken.
- MEM_MemRead_i  input  1  instruction in MEM reads data memory.
- MEM_MemWrite_i  input  1  instruction in MEM writes data memory.
- mem_ack_i  input  1  data memory completes the access (one-cycle pulse).
- mem_req_o  output  1  registered request to data memory.
- PCWrite_o  output  1  PC update enable.
- IF_ID_Write_o  output  1  IF/ID register write enable.
- IF_ID_Flush_o  output  1  clear IF/ID to NOP.
- ID_EX_NoOp_o  output  1  force ID/EX control bits to zero (bubble).
- Freeze_o  output  1  hold every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- err_o  output  1  sticky memory-timeout error.
- loaduse_cnt_o  output  CNT_W  load-use stall cycles, saturating.
- memwait_cnt_o  output  CNT_W  memory freeze cycles, saturating.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=RUN; mem_req_o=0; err_o=0; wait counter=0; both performance counters=0.
  - Combinational outputs then take their RUN values for the current inputs.
- Signal definitions:
  - mem_access = MEM_MemRead_i | MEM_MemWrite_i.
  - load_use = EX_MemRead_i & (EX_RDaddr_i != 0) & (EX_RDaddr_i == ID_RS1addr_i | EX_RDaddr_i == ID_RS2addr_i).
  - rd=x0 never causes a stall.
- FSM state RUN:
  - If mem_access: go to WAIT next cycle, set mem_req_o=1, clear wait counter. Freeze_o=1 this cycle, so the access instruction stays in MEM.
  - Else if load_use: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_NoOp_o=1, IF_ID_Flush_o=0.
  - Else if ID_BranchTaken_i: IF_ID_Flush_o=1.
  - Else all enables are 1 and all NoOp/flush outputs are 0.
- FSM state WAIT:
  - mem_req_o held at 1.
  - Freeze_o = !mem_ack_i.
  - While frozen: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_NoOp_o=0, IF_ID_Flush_o=0.
  - On mem_ack_i: mem_req_o falls next cycle and the state returns to RUN.
  - The ack cycle is not frozen: the pipeline advances, and load_use/branch rules apply as in RUN.
  - Back in RUN the next cycle, the new MEM occupant is evaluated fresh, so back-to-back accesses each take their own handshake.
  - The wait counter increments every WAIT cycle without ack. When it reaches TIMEOUT-1 with no ack: go to ERR next cycle and set err_o=1.
- FSM state ERR:
  - Freeze_o=1, PCWrite_o=0, mem_req_o=0, err_o=1.
  - Left only by reset.
- Priority: freeze > load-use > branch flush.
  - Load-use together with a taken branch: the stall wins and the flush is suppressed. The branch re-resolves after the bubble.
- Freeze_o=1 forces PCWrite_o=0 and IF_ID_Write_o=0.
- Counters:
  - loaduse_cnt_o increments on each cycle in which ID_EX_NoOp_o=1.
  - memwait_cnt_o increments on each cycle in which Freeze_o=1 (RUN detect cycle, WAIT and ERR all count).
  - Both saturate at all-ones and never wrap.
- mem_ack_i while in RUN or ERR is ignored.
- Reset mid-WAIT drops mem_req_o immediately (asynchronously).

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding RUN=2'd0, WAIT=2'd1, ERR=2'd2;
  - register-address width constant REG_AW=5;
  - localparam X0=5'd0.
- One natural sub-module: load_use_compare, the purely combinational load_use term, so it can be verified alone.
- FSM, timeout counter and performance counters stay in the top module.

Test Plan:
1. Load-use: EX_MemRead_i=1, EX_RDaddr_i=5, ID_RS2addr_i=5 -> one cycle of PCWrite_o=0, IF_ID_Write_o=0, ID_EX_NoOp_o=1; loaduse_cnt_o=1.
2. x0 guard: EX_MemRead_i=1, EX_RDaddr_i=0, ID_RS1addr_i=0 -> no stall; all enables 1.
3. Memory handshake: MEM_MemRead_i=1, mem_ack_i after 3 WAIT cycles -> Freeze_o=1 for 4 cycles; mem_req_o high cycles 1-4; pipeline advances on the ack cycle; memwait_cnt_o=4.
4. Priority: load_use=1 and ID_BranchTaken_i=1 in the same cycle -> ID_EX_NoOp_o=1, IF_ID_Flush_o=0. Next cycle branch alone -> IF_ID_Flush_o=1.
5. Timeout: TIMEOUT=8, no ack -> err_o=1 after 8 WAIT cycles; Freeze_o stays 1 and mem_req_o=0. rst_i low mid-ERR clears err_o and the counters asynchronously.
6. Saturation: CNT_W=4, 20 consecutive load-use stalls -> loaduse_cnt_o holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard scheduler
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_noop;
        logic freeze;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FROZEN = '{
        pc_write:    1'b0,
        if_id_write: 1'b0,
        if_id_flush: 1'b0,
        id_ex_noop:  1'b0,
        freeze:      1'b1
    };

    // Unfrozen pipeline controls: a load-use stall outranks a taken-branch flush.
    function automatic pipe_ctrl_t run_ctrl(input logic load_use, input logic branch_taken);
        pipe_ctrl_t c;
        c = '{
            pc_write:    1'b1,
            if_id_write: 1'b1,
            if_id_flush: 1'b0,
            id_ex_noop:  1'b0,
            freeze:      1'b0
        };
        if (load_use) begin
            c.pc_write    = 1'b0;
            c.if_id_write = 1'b0;
            c.id_ex_noop  = 1'b1;
        end else if (branch_taken) begin
            c.if_id_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_scheduler_if.sv
// rtl/pipeline_hazard_scheduler_if.sv - hazard inputs, memory handshake and pipeline controls
interface pipeline_hazard_scheduler_if #(
    parameter int CNT_W = 16
);
    import pipe_ctrl_pkg::*;

    logic [REG_AW-1:0] ID_RS1addr_i;
    logic [REG_AW-1:0] ID_RS2addr_i;
    logic [REG_AW-1:0] EX_RDaddr_i;
    logic              EX_MemRead_i;
    logic              ID_BranchTaken_i;
    logic              MEM_MemRead_i;
    logic              MEM_MemWrite_i;
    logic              mem_ack_i;
    logic              mem_req_o;
    logic              PCWrite_o;
    logic              IF_ID_Write_o;
    logic              IF_ID_Flush_o;
    logic              ID_EX_NoOp_o;
    logic              Freeze_o;
    logic              err_o;
    logic [CNT_W-1:0]  loaduse_cnt_o;
    logic [CNT_W-1:0]  memwait_cnt_o;

    modport master (
        output ID_RS1addr_i, ID_RS2addr_i, EX_RDaddr_i, EX_MemRead_i, ID_BranchTaken_i,
               MEM_MemRead_i, MEM_MemWrite_i, mem_ack_i,
        input  mem_req_o, PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_NoOp_o,
               Freeze_o, err_o, loaduse_cnt_o, memwait_cnt_o
    );

    modport slave (
        input  ID_RS1addr_i, ID_RS2addr_i, EX_RDaddr_i, EX_MemRead_i, ID_BranchTaken_i,
               MEM_MemRead_i, MEM_MemWrite_i, mem_ack_i,
        output mem_req_o, PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_NoOp_o,
               Freeze_o, err_o, loaduse_cnt_o, memwait_cnt_o
    );

endinterface

// File: rtl/load_use_compare.sv
// rtl/load_use_compare.sv - combinational load-use hazard detect between EX and ID
module load_use_compare
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] ID_RS1addr_i,
    input  logic [REG_AW-1:0] ID_RS2addr_i,
    input  logic [REG_AW-1:0] EX_RDaddr_i,
    input  logic              EX_MemRead_i,
    output logic              load_use_o
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use_o = EX_MemRead_i
                      && (EX_RDaddr_i != X0)
                      && ((EX_RDaddr_i == ID_RS1addr_i) || (EX_RDaddr_i == ID_RS2addr_i));

endmodule

// File: rtl/pipeline_hazard_scheduler.sv
// rtl/pipeline_hazard_scheduler.sv - stall/flush/freeze sequencer for the 5-stage pipeline
module pipeline_hazard_scheduler
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    pipeline_hazard_scheduler_if.slave bus
);

    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    sched_state_e      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  loaduse_cnt_q;
    logic [CNT_W-1:0]  memwait_cnt_q;
    logic              load_use;
    logic              mem_access;
    pipe_ctrl_t        ctrl;

    load_use_compare u_load_use_compare (
        .ID_RS1addr_i (bus.ID_RS1addr_i),
        .ID_RS2addr_i (bus.ID_RS2addr_i),
        .EX_RDaddr_i  (bus.EX_RDaddr_i),
        .EX_MemRead_i (bus.EX_MemRead_i),
        .load_use_o   (load_use)
    );

    assign mem_access = bus.MEM_MemRead_i | bus.MEM_MemWrite_i;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
        ctrl       = run_ctrl(load_use, bus.ID_BranchTaken_i);
        case (state_q)
            RUN: begin
                // Freeze on detection so the access instruction stays parked in MEM.
                if (mem_access) begin
                    ctrl       = CTRL_FROZEN;
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    wait_cnt_d = '0;
                end
            end
            WAIT: begin
                // The ack cycle itself advances the pipeline; a new MEM occupant is judged next cycle.
                if (bus.mem_ack_i) begin
                    state_d   = RUN;
                    mem_req_d = 1'b0;
                end else begin
                    ctrl = CTRL_FROZEN;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = ERR;
                        mem_req_d = 1'b0;
                        err_d     = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            ERR: begin
                ctrl      = CTRL_FROZEN;
                mem_req_d = 1'b0;
                err_d     = 1'b1;
            end
            default: begin
                state_d   = RUN;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= RUN;
            mem_req_q  <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            loaduse_cnt_q <= '0;
            memwait_cnt_q <= '0;
        end else begin
            if (ctrl.id_ex_noop && (loaduse_cnt_q != CNT_MAX)) begin
                loaduse_cnt_q <= loaduse_cnt_q + CNT_W'(1);
            end
            if (ctrl.freeze && (memwait_cnt_q != CNT_MAX)) begin
                memwait_cnt_q <= memwait_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.mem_req_o     = mem_req_q;
    assign bus.err_o         = err_q;
    assign bus.PCWrite_o     = ctrl.pc_write;
    assign bus.IF_ID_Write_o = ctrl.if_id_write;
    assign bus.IF_ID_Flush_o = ctrl.if_id_flush;
    assign bus.ID_EX_NoOp_o  = ctrl.id_ex_noop;
    assign bus.Freeze_o      = ctrl.freeze;
    assign bus.loaduse_cnt_o = loaduse_cnt_q;
    assign bus.memwait_cnt_o = memwait_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// tb/tb_pipeline_hazard_scheduler.sv - directed and randomized checks of pipeline_hazard_scheduler
module tb_pipeline_hazard_scheduler;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0 = pipeline running, 1 = waiting for memory, 2 = memory error.
    int m_mode;
    int m_waited;
    int m_lu;
    int m_mw;
    bit e_pcw, e_ifw, e_flush, e_noop, e_freeze;

    pipeline_hazard_scheduler_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_scheduler #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_waited = 0;
        m_lu     = 0;
        m_mw     = 0;
    endtask

    function automatic bit hazard();
        return bus.EX_MemRead_i && (bus.EX_RDaddr_i != 0)
            && ((bus.EX_RDaddr_i == bus.ID_RS1addr_i) || (bus.EX_RDaddr_i == bus.ID_RS2addr_i));
    endfunction

    task automatic model_outputs();
        bit lu;
        bit acc;
        lu       = hazard();
        acc      = bus.MEM_MemRead_i || bus.MEM_MemWrite_i;
        e_freeze = (m_mode == 2) || (m_mode == 0 && acc) || (m_mode == 1 && !bus.mem_ack_i);
        e_noop   = !e_freeze && lu;
        e_flush  = !e_freeze && !lu && bus.ID_BranchTaken_i;
        e_pcw    = !e_freeze && !lu;
        e_ifw    = e_pcw;
    endtask

    task automatic model_advance();
        bit acc;
        acc = bus.MEM_MemRead_i || bus.MEM_MemWrite_i;
        if (e_noop)   m_lu = (m_lu < CNT_MAX) ? m_lu + 1 : CNT_MAX;
        if (e_freeze) m_mw = (m_mw < CNT_MAX) ? m_mw + 1 : CNT_MAX;
        if (m_mode == 0 && acc) begin
            m_mode   = 1;
            m_waited = 0;
        end else if (m_mode == 1) begin
            if (bus.mem_ack_i) begin
                m_mode = 0;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) m_mode = 2;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s.pcwrite", tag),  bus.PCWrite_o,     e_pcw);
        chk($sformatf("%s.ifid_wr", tag),  bus.IF_ID_Write_o, e_ifw);
        chk($sformatf("%s.flush", tag),    bus.IF_ID_Flush_o, e_flush);
        chk($sformatf("%s.noop", tag),     bus.ID_EX_NoOp_o,  e_noop);
        chk($sformatf("%s.freeze", tag),   bus.Freeze_o,      e_freeze);
        chk($sformatf("%s.mem_req", tag),  bus.mem_req_o,     m_mode == 1);
        chk($sformatf("%s.err", tag),      bus.err_o,         m_mode == 2);
        chk($sformatf("%s.lu_cnt", tag),   bus.loaduse_cnt_o, m_lu);
        chk($sformatf("%s.mw_cnt", tag),   bus.memwait_cnt_o, m_mw);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic ex_rd, input logic br, input logic mrd, input logic mwr,
                         input logic ack);
        bus.ID_RS1addr_i     = rs1;
        bus.ID_RS2addr_i     = rs2;
        bus.EX_RDaddr_i      = rd;
        bus.EX_MemRead_i     = ex_rd;
        bus.ID_BranchTaken_i = br;
        bus.MEM_MemRead_i    = mrd;
        bus.MEM_MemWrite_i   = mwr;
        bus.mem_ack_i        = ack;
        #1;
    endtask

    task automatic run_cycle(input string tag);
        model_outputs();
        check_all(tag);
        model_advance();
        @(negedge clk_i);
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b0;
        #1;
        model_reset();
        model_outputs();
        check_all(tag);
        chk($sformatf("%s.rst_err", tag),     bus.err_o,         0);
        chk($sformatf("%s.rst_req", tag),     bus.mem_req_o,     0);
        chk($sformatf("%s.rst_lu_cnt", tag),  bus.loaduse_cnt_o, 0);
        chk($sformatf("%s.rst_mw_cnt", tag),  bus.memwait_cnt_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk_i);
        do_reset("reset");

        drive(5'd3, 5'd5, 5'd5, 1, 0, 0, 0, 0);
        chk("t1_pcwrite", bus.PCWrite_o, 0);
        chk("t1_ifid_wr", bus.IF_ID_Write_o, 0);
        chk("t1_noop", bus.ID_EX_NoOp_o, 1);
        run_cycle("t1");
        drive(5'd1, 5'd2, 5'd5, 0, 0, 0, 0, 0);
        chk("t1_lu_cnt", bus.loaduse_cnt_o, 1);
        run_cycle("t1_after");

        drive(0, 0, 0, 1, 0, 0, 0, 0);
        chk("t2_pcwrite", bus.PCWrite_o, 1);
        chk("t2_ifid_wr", bus.IF_ID_Write_o, 1);
        chk("t2_noop", bus.ID_EX_NoOp_o, 0);
        run_cycle("t2");

        for (int c = 0; c < 5; c++) begin
            drive(5'd1, 5'd2, 5'd3, 0, 0, 1, 0, c == 4);
            chk("t3_freeze", bus.Freeze_o, c < 4);
            chk("t3_req", bus.mem_req_o, c >= 1);
            chk("t3_pcwrite", bus.PCWrite_o, c == 4);
            run_cycle("t3");
        end
        drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
        chk("t3_req_drop", bus.mem_req_o, 0);
        chk("t3_mw_cnt", bus.memwait_cnt_o, 4);
        run_cycle("t3_after");

        drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0);
        run_cycle("b2b_detect");
        drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 1);
        chk("b2b_ack_freeze", bus.Freeze_o, 0);
        run_cycle("b2b_ack");
        drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0);
        chk("b2b_redetect_freeze", bus.Freeze_o, 1);
        chk("b2b_redetect_req", bus.mem_req_o, 0);
        run_cycle("b2b_redetect");
        drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 1);
        run_cycle("b2b_ack2");

        drive(5'd7, 5'd9, 5'd7, 1, 1, 0, 0, 0);
        chk("t4_noop", bus.ID_EX_NoOp_o, 1);
        chk("t4_flush", bus.IF_ID_Flush_o, 0);
        run_cycle("t4_both");
        drive(5'd7, 5'd9, 5'd4, 0, 1, 0, 0, 0);
        chk("t4_branch_flush", bus.IF_ID_Flush_o, 1);
        chk("t4_branch_pcwrite", bus.PCWrite_o, 1);
        run_cycle("t4_branch");

        for (int c = 0; c < 9; c++) begin
            drive(5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
            chk("t5_no_err_yet", bus.err_o, 0);
            run_cycle("t5_wait");
        end
        drive(5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
        chk("t5_err", bus.err_o, 1);
        chk("t5_err_req", bus.mem_req_o, 0);
        chk("t5_err_freeze", bus.Freeze_o, 1);
        chk("t5_err_pcwrite", bus.PCWrite_o, 0);
        run_cycle("t5_err");
        drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1);
        chk("t5_ack_ignored", bus.Freeze_o, 1);
        run_cycle("t5_ack_in_err");
        #2;
        do_reset("t5_err_reset");

        drive(5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
        run_cycle("wr_detect");
        drive(5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
        chk("wr_req_high", bus.mem_req_o, 1);
        run_cycle("wr_wait");
        #2;
        do_reset("wait_reset");

        for (int c = 0; c < 20; c++) begin
            drive(5'd6, 5'd1, 5'd6, 1, 0, 0, 0, 0);
            run_cycle("t6_stall");
        end
        drive(5'd6, 5'd1, 5'd2, 0, 0, 0, 0, 0);
        chk("t6_saturated", bus.loaduse_cnt_o, CNT_MAX);
        run_cycle("t6_after");

        for (int c = 0; c < 400; c++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 2) == 0));
            run_cycle("rnd");
            if (m_mode == 2 && $urandom_range(0, 2) == 0) begin
                #2;
                do_reset("rnd_reset");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
